score_bcd_counter: RTL

Produces the decimal digits driven onto the 7-segment HEX displays: a multi-digit BCD score counter for the copter game. It advances one point per `TICKS_PER_POINT` frame ticks while the game runs, freezes on game over, and optionally tracks a high score. Each 4-bit digit slice is zero-extended by the top level into the per-digit decimal-to-7-segment decoders.

---
 rtl/score_bcd_counter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/score_bcd_counter.sv
// Multi-digit BCD game score: prescaled frame ticks, saturation, freeze on game over.
// Optional high-score register and new_high pulse when SCORE_HIGHSCORE_EN is defined.
module score_bcd_counter #(
    parameter int DIGITS          = 6,
    parameter int TICKS_PER_POINT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                tick,
    input  logic                clear,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic                overflow,
`ifdef SCORE_HIGHSCORE_EN
    output logic [4*DIGITS-1:0] hi_bcd,
    output logic                new_high,
`endif
    output logic [1:0]          state_dbg
);
    // state_dbg encoding: 0 = IDLE, 1 = RUNNING, 2 = FROZEN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_FROZEN  = 2'd2
    } state_t;

    localparam int            SW     = 4 * DIGITS;
    localparam int            PW     = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICKS_PER_POINT - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] pres_q, pres_d;
    logic [SW-1:0] score_q, score_d;
    logic          ovf_q, ovf_d;
    logic [SW-1:0] score_inc;
    logic          all_nines;
    logic          point;

    // Ripple BCD increment; a carry out of the top digit means the score is all 9s.
    always_comb begin : bcd_inc
        logic carry;
        carry     = 1'b1;
        score_inc = score_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    always_comb begin
        state_d = state_q;
        pres_d  = pres_q;
        score_d = score_q;
        ovf_d   = ovf_q;
        point   = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            pres_d  = '0;
            score_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) state_d = S_RUNNING;
                end
                S_RUNNING: begin
                    if (tick) begin
                        if (pres_q == PS_MAX) begin
                            pres_d = '0;
                            point  = 1'b1;
                        end else begin
                            pres_d = pres_q + PW'(1);
                        end
                    end
                    if (!run) state_d = S_FROZEN;
                end
                S_FROZEN: state_d = S_FROZEN;
                default:  state_d = S_IDLE;
            endcase
            if (point) begin
                if (all_nines) ovf_d = 1'b1;
                else           score_d = score_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pres_q  <= '0;
            score_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pres_q  <= pres_d;
            score_q <= score_d;
            ovf_q   <= ovf_d;
        end
    end

    assign score_bcd = score_q;
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

`ifdef SCORE_HIGHSCORE_EN
    logic [SW-1:0] hi_q, hi_d;
    logic          nh_q, nh_d;
    logic          frozen_seen_q;

    // Valid BCD digits order the same as binary, so a plain vector compare suffices.
    always_comb begin
        hi_d = hi_q;
        nh_d = 1'b0;
        if (!clear && state_q == S_FROZEN && !frozen_seen_q && score_q > hi_q) begin
            hi_d = score_q;
            nh_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q          <= '0;
            nh_q          <= 1'b0;
            frozen_seen_q <= 1'b0;
        end else begin
            hi_q          <= hi_d;
            nh_q          <= nh_d;
            frozen_seen_q <= (state_q == S_FROZEN);
        end
    end

    assign hi_bcd   = hi_q;
    assign new_high = nh_q;
`endif

endmodule
